// File: rtl/convolver_pkg.sv
// ----------------------------------------------------------------------------
// convolver_pkg
// Shared definitions for the convolver datapath stages.
//   state_t      : accumulator FSM state encoding (IDLE / ACCUM / DONE)
//   clog2        : ceiling log2 for elaboration-time sizing
//   num_taps     : KERNEL_SIZE**2
//   beats        : clocks needed to reduce all taps at LANES per clock
//   sat_max/min  : signed saturation limits for a given output width
// ----------------------------------------------------------------------------
package convolver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    function automatic int unsigned num_taps(input int unsigned kernel_size);
        return kernel_size * kernel_size;
    endfunction

    function automatic int unsigned beats(input int unsigned kernel_size,
                                          input int unsigned lanes);
        return num_taps(kernel_size) / lanes;
    endfunction

    function automatic longint sat_max(input int unsigned data_width);
        return (longint'(1) <<< (data_width - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned data_width);
        return -(longint'(1) <<< (data_width - 1));
    endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// ----------------------------------------------------------------------------
// product_accumulator_if
// Handshake bundle between the multiplier stage, the product accumulator and
// the output pixel buffer.
//   in_valid/in_ready   : product vector handshake (upstream -> accumulator)
//   products            : NUM_TAPS signed lanes, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//   bias                : optional initial accumulator value
//                         (present only with PRODUCT_ACCUMULATOR_BIAS_EN)
//   out_valid/out_ready : sum handshake (accumulator -> downstream)
//   sum, overflow       : saturated result and clamp flag
// Modports: master = upstream/downstream side, slave = accumulator.
// ----------------------------------------------------------------------------
interface product_accumulator_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_TAPS   = 25
);
    logic                           in_valid;
    logic                           in_ready;
    logic [NUM_TAPS*DATA_WIDTH-1:0] products;
`ifdef PRODUCT_ACCUMULATOR_BIAS_EN
    logic signed [DATA_WIDTH-1:0]   bias;
`endif
    logic                           out_valid;
    logic                           out_ready;
    logic [DATA_WIDTH-1:0]          sum;
    logic                           overflow;

    modport master (
        output in_valid,
        output products,
`ifdef PRODUCT_ACCUMULATOR_BIAS_EN
        output bias,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  sum,
        input  overflow
    );

    modport slave (
        input  in_valid,
        input  products,
`ifdef PRODUCT_ACCUMULATOR_BIAS_EN
        input  bias,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output sum,
        output overflow
    );
endinterface

// File: rtl/product_accumulator_saturate_clamp.sv
// ----------------------------------------------------------------------------
// saturate_clamp
// Combinational clamp of a signed ACC_WIDTH value into signed DATA_WIDTH.
//   i_acc      : signed accumulator value
//   o_value    : clamped value (SAT_MAX / SAT_MIN / low bits)
//   o_overflow : high when clamping occurred
// ----------------------------------------------------------------------------
module saturate_clamp
    import convolver_pkg::*;
#(
    parameter int unsigned ACC_WIDTH  = 24,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic signed [ACC_WIDTH-1:0] i_acc,
    output logic [DATA_WIDTH-1:0]       o_value,
    output logic                        o_overflow
);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(DATA_WIDTH));

    always_comb begin
        o_value    = i_acc[DATA_WIDTH-1:0];
        o_overflow = 1'b0;
        if (i_acc > SAT_MAX) begin
            o_value    = SAT_MAX[DATA_WIDTH-1:0];
            o_overflow = 1'b1;
        end else if (i_acc < SAT_MIN) begin
            o_value    = SAT_MIN[DATA_WIDTH-1:0];
            o_overflow = 1'b1;
        end
    end
endmodule

// File: rtl/product_accumulator.sv
// ----------------------------------------------------------------------------
// product_accumulator
// Reduces KERNEL_SIZE**2 signed tap products into one saturated pixel,
// adding LANES products per clock over BEATS clocks.
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset
//   bus      : product_accumulator_if.slave (in/out handshakes, products,
//              sum, overflow, optional bias)
// Optional feature: define PRODUCT_ACCUMULATOR_BIAS_EN to add a bias input
// that seeds the accumulator on the accepting edge.
// ----------------------------------------------------------------------------
module product_accumulator
    import convolver_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned LANES       = 5,
    parameter int unsigned ACC_WIDTH   = 24
) (
    input logic                 clk,
    input logic                 reset_n,
    product_accumulator_if.slave bus
);
    localparam int unsigned NUM_TAPS  = num_taps(KERNEL_SIZE);
    localparam int unsigned BEATS     = beats(KERNEL_SIZE, LANES);
    localparam int unsigned BEAT_W    = (clog2(BEATS) > 0) ? clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_t                         r_state;
    state_t                         w_state_next;
    logic [NUM_TAPS*DATA_WIDTH-1:0] r_vec;
    logic signed [ACC_WIDTH-1:0]    r_acc;
    logic signed [ACC_WIDTH-1:0]    w_beat_sum;
    logic signed [ACC_WIDTH-1:0]    w_acc_next;
    logic signed [ACC_WIDTH-1:0]    w_init_acc;
    logic [BEAT_W-1:0]              r_beat;
    logic [DATA_WIDTH-1:0]          r_sum;
    logic                           r_overflow;
    logic [DATA_WIDTH-1:0]          w_clamp_value;
    logic                           w_clamp_ovf;
    logic                           w_accept;
    logic                           w_last;

    assign w_accept = (r_state == IDLE) && bus.in_valid;
    assign w_last   = (r_state == ACCUM) && (r_beat == LAST_BEAT);

`ifdef PRODUCT_ACCUMULATOR_BIAS_EN
    assign w_init_acc = ACC_WIDTH'(bus.bias);
`else
    assign w_init_acc = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and handshake outputs
    always_comb begin
        w_state_next  = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (r_beat == LAST_BEAT) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Sign-extended sum of the LANES products selected by the current beat
    always_comb begin
        w_beat_sum = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            w_beat_sum = w_beat_sum + ACC_WIDTH'(signed'(
                r_vec[(int'(r_beat) * LANES + l) * DATA_WIDTH +: DATA_WIDTH]));
        end
    end

    assign w_acc_next = r_acc + w_beat_sum;

    saturate_clamp #(
        .ACC_WIDTH  (ACC_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_clamp (
        .i_acc      (w_acc_next),
        .o_value    (w_clamp_value),
        .o_overflow (w_clamp_ovf)
    );

    // Datapath: capture, accumulate, register the clamped final total
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vec      <= '0;
            r_acc      <= '0;
            r_beat     <= '0;
            r_sum      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_vec  <= bus.products;
                r_acc  <= w_init_acc;
                r_beat <= '0;
            end else if (r_state == ACCUM) begin
                r_acc  <= w_acc_next;
                r_beat <= r_beat + BEAT_W'(1);
                if (w_last) begin
                    r_sum      <= w_clamp_value;
                    r_overflow <= w_clamp_ovf;
                end
            end
        end
    end

    assign bus.sum      = r_sum;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_product_accumulator.sv
// ----------------------------------------------------------------------------
// tb_product_accumulator
// Directed and randomized checks of product_accumulator against an
// arithmetic reference (plain integer sum of lanes, then clamp).
// ----------------------------------------------------------------------------
module tb_product_accumulator;
    localparam int DW = 16;
    localparam int NT = 25;

    logic clk;
    logic reset_n;

    int n_checks;
    int n_fail;
    int lanes [NT];
    int bias_v;

    product_accumulator_if #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) bus ();

    product_accumulator #(
        .DATA_WIDTH  (DW),
        .KERNEL_SIZE (5),
        .LANES       (5),
        .ACC_WIDTH   (24)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_products();
        for (int j = 0; j < NT; j++) begin
            bus.products[j*DW +: DW] = 16'(lanes[j]);
        end
`ifdef PRODUCT_ACCUMULATOR_BIAS_EN
        bus.bias = 16'(bias_v);
`endif
    endtask

    task automatic scramble_products();
        for (int j = 0; j < NT; j++) begin
            bus.products[j*DW +: DW] = 16'($urandom);
        end
`ifdef PRODUCT_ACCUMULATOR_BIAS_EN
        bus.bias = 16'($urandom);
`endif
    endtask

    // Reference: exact integer total, then clamp to signed 16 bits
    function automatic void model(output logic [15:0] es, output logic eo);
        longint tot;
        tot = longint'(bias_v);
        for (int j = 0; j < NT; j++) tot += longint'(lanes[j]);
        if (tot > 32767) begin
            es = 16'h7FFF; eo = 1'b1;
        end else if (tot < -32768) begin
            es = 16'h8000; eo = 1'b1;
        end else begin
            es = 16'(tot); eo = 1'b0;
        end
    endfunction

    task automatic wait_in_ready(input string tag);
        int n;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic wait_out_valid(input string tag);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1; n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd5);
    endtask

    // One full transaction with out_ready held high
    task automatic run_vector(input string tag);
        logic [15:0] es;
        logic        eo;
        model(es, eo);
        load_products();
        wait_in_ready(tag);
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        scramble_products();
        wait_out_valid(tag);
        check({tag, "_sum"}, 32'(bus.sum), 32'(es));
        check({tag, "_ovf"}, 32'(bus.overflow), 32'(eo));
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [15:0] es;
        logic        eo;
        int          seen;

        n_checks      = 0;
        n_fail        = 0;
        bias_v        = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.products  = '0;
`ifdef PRODUCT_ACCUMULATOR_BIAS_EN
        bus.bias      = '0;
`endif
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Reset state
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_sum",       32'(bus.sum),       32'd0);
        check("rst_ovf",       32'(bus.overflow),  32'd0);

        // All ones -> 25
        for (int j = 0; j < NT; j++) lanes[j] = 1;
        run_vector("ones");

        // Symmetric ramp -> 0
        for (int j = 0; j < NT; j++) lanes[j] = j - 12;
        run_vector("ramp");

        // Positive and negative saturation
        for (int j = 0; j < NT; j++) lanes[j] = 32767;
        run_vector("satpos");
        for (int j = 0; j < NT; j++) lanes[j] = -32768;
        run_vector("satneg");

        // Randomized vectors: small, full range, and biased toward the rails
        for (int t = 0; t < 9; t++) begin
            for (int j = 0; j < NT; j++) begin
                case (t % 3)
                    0:       lanes[j] = int'($urandom_range(200)) - 100;
                    1:       lanes[j] = int'($urandom_range(65535)) - 32768;
                    default: lanes[j] = int'($urandom_range(3000)) - 1200;
                endcase
            end
`ifdef PRODUCT_ACCUMULATOR_BIAS_EN
            bias_v = int'($urandom_range(2000)) - 1000;
`endif
            run_vector($sformatf("rand%0d", t));
        end
        bias_v = 0;

        // Backpressure with an ignored in_valid while in DONE
        for (int j = 0; j < NT; j++) lanes[j] = int'($urandom_range(600)) - 300;
        model(es, eo);
        load_products();
        wait_in_ready("bp");
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        scramble_products();
        wait_out_valid("bp");
        check("bp_sum", 32'(bus.sum), 32'(es));
        check("bp_ovf", 32'(bus.overflow), 32'(eo));
        for (int c = 0; c < 4; c++) begin
            bus.in_valid = 1'b1;
            for (int j = 0; j < NT; j++) bus.products[j*DW +: DW] = 16'h0100;
            @(posedge clk); #1;
            check($sformatf("bp_hold_valid%0d", c), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_hold_sum%0d", c),   32'(bus.sum),       32'(es));
            check($sformatf("bp_hold_ovf%0d", c),   32'(bus.overflow),  32'(eo));
            check($sformatf("bp_hold_rdy%0d", c),   32'(bus.in_ready),  32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_ready", 32'(bus.in_ready),  32'd1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("bp_no_second", 32'(seen), 32'd0);

        // Reset in the middle of accumulation
        for (int j = 0; j < NT; j++) lanes[j] = 16;
        load_products();
        wait_in_ready("mid");
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        check("mid_ready", 32'(bus.in_ready), 32'd1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("mid_no_valid", 32'(seen), 32'd0);
        for (int j = 0; j < NT; j++) lanes[j] = 2;
        run_vector("after_rst");

`ifdef PRODUCT_ACCUMULATOR_BIAS_EN
        // Bias cancels the all-ones total
        for (int j = 0; j < NT; j++) lanes[j] = 1;
        bias_v = -25;
        run_vector("bias");
        bias_v = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end
endmodule
